freq_meter: RTL

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 21 ++
 rtl/freq_meter_sync_edge_detect.sv | 34 +++
 rtl/freq_meter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared FSM encodings, default parameters and sizing helper
// for the frequency meter and blocks that reuse its conventions.
package freq_meter_pkg;

    localparam int unsigned FM_GATE_CYCLES_DEF = 100000;
    localparam int unsigned FM_CNT_WIDTH_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } fm_state_t;

    // Gate counter width; kept at least 1 bit so a 1-cycle window stays legal.
    function automatic int unsigned gate_cnt_width(input int unsigned gate_cycles);
        int unsigned w;
        w = $clog2(gate_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus delay flop, flags a rising edge
// of an asynchronous input one CLK cycle wide.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-high reset, clears all three flops
//   d    - asynchronous input
//   rise - high for one cycle when the synchronized input goes 0 -> 1
module sync_edge_detect (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic rise
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchronizer chain (s1, s2) and history flop (s3)
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of SIG_IN over windows of GATE_CYCLES CLK
// cycles and reports the saturated count once per window.
// Ports:
//   CLK    - clock, rising edge
//   RST    - synchronous active-high reset
//   SIG_IN - signal under measurement, asynchronous to CLK
//   EN     - run windows back-to-back while high; low aborts/idles
//   COUNT  - edge count of the last completed window (saturating)
//   VALID  - one-cycle pulse when COUNT/OVF update
//   OVF    - last completed window saturated the counter
//   BUSY   - a window is in progress
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = FM_GATE_CYCLES_DEF,
    parameter int unsigned CNT_WIDTH   = FM_CNT_WIDTH_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SIG_IN,
    input  logic                 EN,
    output logic [CNT_WIDTH-1:0] COUNT,
    output logic                 VALID,
    output logic                 OVF,
    output logic                 BUSY
);

    localparam int unsigned          GW        = gate_cnt_width(GATE_CYCLES);
    localparam logic [GW-1:0]        GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    fm_state_t            state_q, state_d;
    logic [GW-1:0]        gate_cnt_q, gate_cnt_d;
    logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic                 ovf_flag_q, ovf_flag_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;

    logic                 rise;
    logic [CNT_WIDTH-1:0] edge_cnt_upd;
    logic                 ovf_flag_upd;

    sync_edge_detect u_sync_edge_detect (
        .CLK  (CLK),
        .RST  (RST),
        .d    (SIG_IN),
        .rise (rise)
    );

    // Saturating edge count including this cycle's edge; an edge seen while
    // already saturated marks the window as overflowed.
    always_comb begin
        edge_cnt_upd = edge_cnt_q;
        ovf_flag_upd = ovf_flag_q;
        if (rise) begin
            if (edge_cnt_q == CNT_MAX) begin
                ovf_flag_upd = 1'b1;
            end else begin
                edge_cnt_upd = edge_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ovf_flag_d = ovf_flag_q;
        count_d    = count_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (EN) begin
                    state_d    = GATE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    ovf_flag_d = 1'b0;
                end
            end
            GATE: begin
                if (!EN) begin
                    // Abort: results from the previous window stay visible
                    state_d = IDLE;
                end else begin
                    gate_cnt_d = gate_cnt_q + GW'(1);
                    edge_cnt_d = edge_cnt_upd;
                    ovf_flag_d = ovf_flag_upd;
                    if (gate_cnt_q == GATE_LAST) begin
                        state_d = DONE;
                        count_d = edge_cnt_upd;
                        ovf_d   = ovf_flag_upd;
                    end
                end
            end
            DONE: begin
                // Dead cycle: edges seen here belong to no window
                if (EN) begin
                    state_d    = GATE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    ovf_flag_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == DONE);
        busy_d  = (state_d == GATE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_flag_q <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_flag_q <= ovf_flag_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign COUNT = count_q;
    assign OVF   = ovf_q;
    assign VALID = valid_q;
    assign BUSY  = busy_q;

endmodule
